// File: rtl/eth_tx_sched.sv
// Two-requester Ethernet transmit scheduler: round-robin frame grant, preamble/SFD insertion, IFG spacing.
// Build option: define ETH_TX_FCS_EN to append the IEEE 802.3 CRC-32 after each payload.
module eth_tx_sched #(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned IFG_BYTES    = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s0_tvalid,
   input  logic [7:0] s0_tdata,
   input  logic       s0_tlast,
   output logic       s0_tready,
   input  logic       s1_tvalid,
   input  logic [7:0] s1_tdata,
   input  logic       s1_tlast,
   output logic       s1_tready,
   output logic       tvalid,
   output logic [7:0] tdata,
   output logic [1:0] grant,
   output logic       underrun
);

   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_DATA = 3'd2,
`ifdef ETH_TX_FCS_EN
      ST_FCS  = 3'd3,
`endif
      ST_IFG  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [1:0]  r_grant;
   logic [1:0]  w_grant_nxt;
   logic        r_last;
   logic        w_last_nxt;
   logic        r_vld_p1;
   logic        w_vld_p0;
   logic [7:0]  r_data_p1;
   logic [7:0]  w_data_p0;
   logic        r_underrun;
   logic        w_underrun_nxt;

   logic        w_any;
   logic        w_pick1;
   logic        w_arb;
   logic        w_in_vld;
   logic [7:0]  w_in_data;
   logic        w_in_last;

`ifdef ETH_TX_FCS_EN
   logic [31:0] r_crc;
   logic [31:0] w_crc_nxt;
   logic [31:0] w_fcs;

   // Reflected CRC-32, one byte per call, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   assign w_fcs = ~r_crc;
`endif

   // Requester 0 wins a tie only when requester 1 was granted last.
   assign w_any     = s0_tvalid | s1_tvalid;
   assign w_pick1   = s1_tvalid & (~s0_tvalid | ~r_last);
   assign w_arb     = (r_state == ST_IDLE) || ((r_state == ST_IFG) && (r_cnt == IFG_LAST));

   assign w_in_vld  = r_grant[1] ? s1_tvalid : s0_tvalid;
   assign w_in_data = r_grant[1] ? s1_tdata  : s0_tdata;
   assign w_in_last = r_grant[1] ? s1_tlast  : s0_tlast;

   assign s0_tready = (r_state == ST_DATA) && r_grant[0];
   assign s1_tready = (r_state == ST_DATA) && r_grant[1];

   assign tvalid    = r_vld_p1;
   assign tdata     = r_data_p1;
   assign grant     = r_grant;
   assign underrun  = r_underrun;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_PRE;
               w_cnt_nxt   = 8'd0;
            end
         end
         ST_PRE: begin
            if (r_cnt == PRE_LAST) begin
               w_state_nxt = ST_DATA;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 8'd1;
            end
         end
         ST_DATA: begin
            // An underrun has already produced its first idle cycle, so its gap count starts at 1.
            if (!w_in_vld) begin
               w_state_nxt = ST_IFG;
               w_cnt_nxt   = 8'd1;
            end else if (w_in_last) begin
`ifdef ETH_TX_FCS_EN
               w_state_nxt = ST_FCS;
`else
               w_state_nxt = ST_IFG;
`endif
               w_cnt_nxt   = 8'd0;
            end
         end
`ifdef ETH_TX_FCS_EN
         ST_FCS: begin
            if (r_cnt == 8'd3) begin
               w_state_nxt = ST_IFG;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 8'd1;
            end
         end
`endif
         ST_IFG: begin
            if (r_cnt == IFG_LAST) begin
               w_state_nxt = w_any ? ST_PRE : ST_IDLE;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_vld_p0       = 1'b0;
      w_data_p0      = 8'h00;
      w_grant_nxt    = r_grant;
      w_last_nxt     = r_last;
      w_underrun_nxt = 1'b0;
`ifdef ETH_TX_FCS_EN
      w_crc_nxt      = r_crc;
`endif
      // The grant edge also launches the first preamble byte.
      if (w_arb) begin
         w_grant_nxt = 2'b00;
         if (w_any) begin
            w_grant_nxt = w_pick1 ? 2'b10 : 2'b01;
            w_last_nxt  = w_pick1;
            w_vld_p0    = 1'b1;
            w_data_p0   = 8'h55;
`ifdef ETH_TX_FCS_EN
            w_crc_nxt   = 32'hFFFF_FFFF;
`endif
         end
      end
      case (r_state)
         ST_PRE: begin
            w_vld_p0  = 1'b1;
            w_data_p0 = (r_cnt == PRE_LAST) ? 8'hD5 : 8'h55;
         end
         ST_DATA: begin
            if (w_in_vld) begin
               w_vld_p0  = 1'b1;
               w_data_p0 = w_in_data;
`ifdef ETH_TX_FCS_EN
               w_crc_nxt = crc32_byte(r_crc, w_in_data);
`endif
            end else begin
               w_underrun_nxt = 1'b1;
            end
         end
`ifdef ETH_TX_FCS_EN
         ST_FCS: begin
            w_vld_p0  = 1'b1;
            w_data_p0 = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
         end
`endif
         default: ;
      endcase
   end

   // Output register stage: byte accepted in one cycle is on tdata the next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p1   <= 1'b0;
         r_data_p1  <= 8'h00;
         r_grant    <= 2'b00;
         r_last     <= 1'b1;
         r_underrun <= 1'b0;
`ifdef ETH_TX_FCS_EN
         r_crc      <= 32'hFFFF_FFFF;
`endif
      end else begin
         r_vld_p1   <= w_vld_p0;
         r_data_p1  <= w_data_p0;
         r_grant    <= w_grant_nxt;
         r_last     <= w_last_nxt;
         r_underrun <= w_underrun_nxt;
`ifdef ETH_TX_FCS_EN
         r_crc      <= w_crc_nxt;
`endif
      end
   end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 Parameter PREAMBLE_LEN, default 7, number of 0x55 preamble bytes before SFD (legal 1..15).
REQ-002 Parameter IFG_BYTES, default 12, minimum idle cycles (tvalid low) between frames (legal 1..255).
REQ-003 clk  input  1  transmit byte clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 s0_tvalid / s0_tdata / s0_tlast  input  1/8/1  requester 0 payload byte stream.
REQ-006 s0_tready  output  1  requester 0 byte accepted when s0_tvalid && s0_tready.
REQ-007 s1_tvalid / s1_tdata / s1_tlast / s1_tready  in/in/in/out  1/8/1/1  requester 1, same rules.
REQ-008 tvalid  output  1  byte-valid to the RGMII transmit stage (drives tx_en).
REQ-009 tdata  output  8  byte to the RGMII transmit stage.
REQ-010 grant  output  2  one-hot owner of the current frame, 2'b00 when idle.
REQ-011 underrun  output  1  one-cycle pulse on frame abort.

Function
REQ-012 States: IDLE, PRE, DATA, FCS (FCS build only), IFG.
REQ-013 Arbitration evaluated in IDLE and in the last IFG cycle: round-robin, priority to requester not granted last; single requester wins alone.
REQ-014 On grant: next cycle state PRE, grant one-hot held until IFG exit.
REQ-015 PRE: tvalid=1, tdata=0x55 for PREAMBLE_LEN cycles, then 0xD5 (SFD) for one cycle; DATA entered on the edge that outputs SFD.
REQ-016 DATA: granted sN_tready=1, other tready=0; tready never asserted outside DATA.
REQ-017 Byte accepted in cycle k appears on tdata with tvalid=1 in cycle k+1 (output registered, latency 1); SFD and payload contiguous.
REQ-018 tlast accepted: leave DATA; next state FCS (FCS build) or IFG.
REQ-019 Granted sN_tvalid low while in DATA = underrun: tvalid=0 next cycle, underrun pulses one cycle, FCS skipped, go IFG; source owns discard of its residue.
REQ-020 IFG: tvalid=0 for exactly IFG_BYTES cycles; with request pending, first preamble byte of next frame follows immediately (gap = IFG_BYTES); else IDLE.
REQ-021 Requests arriving during PRE/DATA/FCS/IFG wait; no preemption.
REQ-022 tdata=0x00 whenever tvalid=0.

Reset
REQ-023 On rising clk with rst_n=0: state IDLE, tvalid=0, tdata=0x00, s0/s1_tready=0, grant=2'b00, underrun=0, last-granted=1 (requester 0 wins first tie), CRC=0xFFFFFFFF, counters 0.
REQ-024 Reset mid-frame truncates the frame; tvalid low the cycle after reset sampled; no IFG enforced after reset release.

Configuration
REQ-025 Macro ETH_TX_FCS_EN defined: CRC-32 (IEEE 802.3, reflected, poly 0x04C11DB7, init 0xFFFFFFFF, final complement) over payload bytes only, appended as 4 bytes LSB first in cycles m+2..m+5 after tlast accepted in cycle m, then IFG.
REQ-026 ETH_TX_FCS_EN undefined: no FCS state or CRC logic; tvalid low from cycle m+2.

Verification
REQ-027 Single frame, s0, 9 bytes "123456789", FCS build, defaults -> 7x0x55, 0xD5, 9 payload bytes, 0x26 0x39 0xF4 0xCB contiguous tvalid; then 12 cycles tvalid=0.
REQ-028 s0 and s1 both requesting from reset, back-to-back 3-byte frames -> order s0,s1,s0,s1; exactly IFG_BYTES idle cycles between frames; grant one-hot matches.
REQ-029 s0 drops tvalid after 2 of 5 bytes -> tvalid=0 cycle after, underrun one pulse, no FCS bytes, 12 idle cycles, s1 pending then served.
REQ-030 rst_n low during payload byte 4 -> tvalid=0, tdata=0x00, grant=00 next cycle; after release new s1 frame starts with full preamble and correct FCS.
REQ-031 Non-FCS build, 1-byte frame 0xA5 -> 0x55x7, 0xD5, 0xA5, then tvalid=0; s0_tready high exactly one cycle.
